fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline: holds the PC, fetches from instruction memory, and loads the IF/ID pipeline register. It sits directly downstream of the ID-stage branch comparator, consuming its `cmpout` result together with the controller's next-PC select to redirect fetch on taken branches, `j`/`jal` and `jr`. It also honours hazard-unit stalls.

## Interface
- `RESET_PC`, default `32'h0000_3000`: PC value loaded on reset.
- `clk` input 1: single clock; all registers update on posedge.
- `reset` input 1: asynchronous, active-high.
- `stall` input 1: from hazard unit; freezes PC and IF/ID.
- `npc_sel` input 2: from ID controller. `00` sequential, `01` conditional branch, `10` `j`/`jal`, `11` `jr`.
- `br_taken` input 1: comparator result (`cmpout`), meaningful only when `npc_sel==01`.
- `rs_val` input 32: forwarded rs value for `jr`.
- `iaddr` output 32: instruction memory address, equal to the PC register (combinational).
- `idata` input 32: instruction word returned combinationally for `iaddr`.
- `ir_d` output 32: IF/ID instruction register.
- `pc4_d` output 32: IF/ID PC+4.
- `pc8_d` output 32: `pc4_d + 4`, the `jal` link value (combinational from `pc4_d`).
- `valid_d` output 1: IF/ID holds a real fetched instruction (0 = bubble).

## Operation
- **Branch target:** `pc4_d + {{14{ir_d[15]}}, ir_d[15:0], 2'b00}`, with 32-bit wrap-around. No overflow detection.
- **Jump target:** `{pc4_d[31:28], ir_d[25:0], 2'b00}`.
- **jr target:** `{rs_val[31:2], 2'b00}`. Low two bits are silently forced to zero.
- **Redirect:** `redirect = valid_d & ((npc_sel==01 & br_taken) | npc_sel==10 | npc_sel==11)`.
  - A bubble in ID (`valid_d==0`) never redirects, whatever `npc_sel` is.
- **Next PC priority, per cycle:**
  1. `stall`: PC holds.
  2. `redirect`: PC = selected target.
  3. Otherwise PC = PC+4.
- **IF/ID load, per cycle:**
  1. `stall`: hold `ir_d`, `pc4_d`, `valid_d`. Stall overrides redirect, because operands in ID are not yet valid.
  2. Otherwise, `redirect` without delay slot: load bubble (`ir_d=0`, `pc4_d=PC+4`, `valid_d=0`).
  3. Otherwise: `ir_d=idata`, `pc4_d=PC+4`, `valid_d=1`.
- `npc_sel==01` with `br_taken==0` behaves as sequential.
- PC+4 wraps from `32'hFFFF_FFFC` to `0`.

## Timing
- Reset (async, takes effect immediately):
  - PC = `RESET_PC`, so `iaddr` = `RESET_PC`.
  - `ir_d` = 0, `pc4_d` = 0, `valid_d` = 0.
  - `pc8_d` = 4 (combinational from `pc4_d`).
- First instruction appears in `ir_d` one posedge after reset deasserts.
- Fetch-to-ID latency: 1 cycle. Redirect decision to new `iaddr`: 1 cycle, taking effect at the same edge that loads IF/ID.
- Taken-branch penalty: 1 bubble without delay slot, 0 with it.
- Stall held N cycles: PC and IF/ID frozen exactly N edges. The redirect is evaluated on the first unstalled edge.
- Reset asserted mid-redirect or mid-stall: reset wins unconditionally, and no pending redirect survives.

## Configuration
- `FETCH_DELAY_SLOT_EN` defined: MIPS branch delay slot.
  - On redirect, IF/ID loads `idata` normally (`valid_d=1`), so the instruction after the branch executes.
- `FETCH_DELAY_SLOT_EN` undefined: on redirect, IF/ID loads a bubble (`ir_d=0`, `valid_d=0`), squashing the wrong-path instruction.

## Test plan
- **Reset/sequential:** reset, release, `npc_sel=00`, no stall.
  - `iaddr` steps 0x3000, 0x3004, 0x3008.
  - `ir_d` equals the word at 0x3000 one cycle after release, with `valid_d=1`.
- **Taken beq:** `ir_d` = beq with imm16 = 0xFFFF, `pc4_d` = 0x3010, `npc_sel=01`, `br_taken=1`.
  - Next `iaddr` = 0x300C.
  - Without macro: `ir_d=0`, `valid_d=0`. With macro: `ir_d` = word at 0x3010.
- **Not-taken bne:** `npc_sel=01`, `br_taken=0`.
  - `iaddr` continues with PC+4.
  - No bubble in either configuration.
- **j and jr:**
  - `j`: index 0x0000C10, `pc4_d` = 0x3020 gives next `iaddr` = 0x3040.
  - `jr`: `rs_val` = 0x3107 gives next `iaddr` = 0x3104.
  - `jal` case: `pc8_d` = 0x3024.
- **Stall over redirect:** taken branch in ID with `stall=1` for 2 cycles.
  - PC and `ir_d` unchanged for 2 edges.
  - Redirect occurs on the 3rd edge.
- **Async reset mid-operation:** assert `reset` between edges while a jump is pending.
  - `iaddr` = 0x3000 and `valid_d=0` immediately, without waiting for an edge.
  - The jump is discarded.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage of a five-stage MIPS pipeline. Holds the PC,
//   presents it to instruction memory and loads the IF/ID pipeline register.
//   Fetch is redirected when the ID stage resolves a taken branch, a j/jal or
//   a jr. Hazard-unit stalls freeze both the PC and IF/ID.
//
//   Build option: define FETCH_DELAY_SLOT_EN for MIPS branch-delay-slot
//   behaviour. With it undefined, the instruction fetched during a redirect
//   is squashed and IF/ID receives a bubble.
//
// Parameters
//   RESET_PC    PC value loaded on reset
//
// Ports
//   clk_i       clock, all registers update on posedge
//   reset_i     asynchronous active-high reset
//   stall_i     hazard-unit stall, freezes PC and IF/ID
//   npc_sel_i   next-PC select: 00 seq, 01 cond. branch, 10 j/jal, 11 jr
//   br_taken_i  branch comparator result, used only when npc_sel_i == 01
//   rs_val_i    forwarded rs value, jr target
//   iaddr_o     instruction memory address (the PC register)
//   idata_i     instruction word for iaddr_o (combinational memory)
//   ir_d_o      IF/ID instruction register
//   pc4_d_o     IF/ID PC+4
//   pc8_d_o     pc4_d_o + 4, jal link value
//   valid_d_o   IF/ID holds a real instruction (0 = bubble)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        stall_i,
    input  logic [1:0]  npc_sel_i,
    input  logic        br_taken_i,
    input  logic [31:0] rs_val_i,
    output logic [31:0] iaddr_o,
    input  logic [31:0] idata_i,
    output logic [31:0] ir_d_o,
    output logic [31:0] pc4_d_o,
    output logic [31:0] pc8_d_o,
    output logic        valid_d_o
);

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    logic [31:0] pc_q,    pc_d;
    logic [31:0] ir_q,    ir_d;
    logic [31:0] pc4_q,   pc4_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_target;
    logic [31:0] redirect_target;
    logic        redirect;

    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc4_q + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    assign j_target  = {pc4_q[31:28], ir_q[25:0], 2'b00};
    assign jr_target = {rs_val_i[31:2], 2'b00};

    // A bubble in ID carries no control decision, so it can never redirect.
    assign redirect = valid_q &
                      (((npc_sel_i == NPC_BR) & br_taken_i) |
                       (npc_sel_i == NPC_J) |
                       (npc_sel_i == NPC_JR));

    always_comb begin
        redirect_target = pc_plus4;
        case (npc_sel_i)
            NPC_BR:  redirect_target = br_target;
            NPC_J:   redirect_target = j_target;
            NPC_JR:  redirect_target = jr_target;
            NPC_SEQ: redirect_target = pc_plus4;
            default: redirect_target = pc_plus4;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        // Stall wins over redirect: ID operands are not yet valid, so the
        // redirect is re-evaluated on the first unstalled edge.
        if (!stall_i) begin
            pc_d  = redirect ? redirect_target : pc_plus4;
            pc4_d = pc_plus4;
`ifdef FETCH_DELAY_SLOT_EN
            ir_d    = idata_i;
            valid_d = 1'b1;
`else
            if (redirect) begin
                ir_d    = 32'd0;
                valid_d = 1'b0;
            end else begin
                ir_d    = idata_i;
                valid_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign iaddr_o   = pc_q;
    assign ir_d_o    = ir_q;
    assign pc4_d_o   = pc4_q;
    assign pc8_d_o   = pc4_q + 32'd4;
    assign valid_d_o = valid_q;

endmodule
